// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the data-memory side of dm_arbiter.
// slave: the arbiter's view; master: a requester/environment view.
interface dm_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [31:0] p0_pc;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        p1_err;

  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ren;
  logic        dm_wen;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_pc,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output dm_addr, dm_wdata, dm_ren, dm_wen, dm_pc,
    input  dm_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_pc,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  dm_addr, dm_wdata, dm_ren, dm_wen, dm_pc,
    output dm_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: one data-memory access per cycle shared between CPU MEM stage (port 0)
// and debug/loader (port 1); round-robin by default, port 0 priority with DM_ARB_FIXED_PRIO_EN.
module dm_arbiter #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] DBG_PC      = 32'h0000_0000
) (
  input logic         clk,
  input logic         reset,
  dm_arbiter_if.slave bus
);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  logic        slot_valid_q, slot_valid_d;
  port_e       slot_port_q,  slot_port_d;
  logic        slot_we_q,    slot_we_d;
  logic [31:0] slot_addr_q,  slot_addr_d;
  logic [31:0] slot_wdata_q, slot_wdata_d;
  logic [31:0] slot_pc_q,    slot_pc_d;
  logic        slot_oor_q,   slot_oor_d;
  port_e       last_grant_q, last_grant_d;

  logic        ret_valid_q,  ret_valid_d;
  port_e       ret_port_q,   ret_port_d;
  logic        ret_err_q,    ret_err_d;
  logic [31:0] p0_rdata_q,   p0_rdata_d;
  logic [31:0] p1_rdata_q,   p1_rdata_d;

  logic        elig0;
  logic        elig1;
  port_e       win;
  logic [31:0] access_rdata;

  always_comb begin
    // The port in its access cycle still holds req; masking it prevents a double grant.
    elig0 = bus.p0_req & ~(slot_valid_q & (slot_port_q == PORT0));
    elig1 = bus.p1_req & ~(slot_valid_q & (slot_port_q == PORT1));

`ifdef DM_ARB_FIXED_PRIO_EN
    win = elig0 ? PORT0 : PORT1;
`else
    if (elig0 && elig1) begin
      win = (last_grant_q == PORT0) ? PORT1 : PORT0;
    end else begin
      win = elig0 ? PORT0 : PORT1;
    end
`endif

    slot_valid_d = 1'b0;
    slot_port_d  = PORT0;
    slot_we_d    = 1'b0;
    slot_addr_d  = '0;
    slot_wdata_d = '0;
    slot_pc_d    = '0;
    last_grant_d = last_grant_q;

    if (elig0 || elig1) begin
      slot_valid_d = 1'b1;
      slot_port_d  = win;
      last_grant_d = win;
      if (win == PORT0) begin
        slot_we_d    = bus.p0_we;
        slot_addr_d  = bus.p0_addr;
        slot_wdata_d = bus.p0_wdata;
        slot_pc_d    = bus.p0_pc;
      end else begin
        slot_we_d    = bus.p1_we;
        slot_addr_d  = bus.p1_addr;
        slot_wdata_d = bus.p1_wdata;
        slot_pc_d    = DBG_PC;
      end
    end
    slot_oor_d = ({2'b00, slot_addr_d[31:2]} >= DEPTH_WORDS);

    ret_valid_d  = slot_valid_q;
    ret_port_d   = slot_port_q;
    ret_err_d    = slot_oor_q;
    access_rdata = (slot_we_q || slot_oor_q) ? '0 : bus.dm_rdata;

    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    if (slot_valid_q && (slot_port_q == PORT0)) p0_rdata_d = access_rdata;
    if (slot_valid_q && (slot_port_q == PORT1)) p1_rdata_d = access_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid_q <= 1'b0;
      slot_port_q  <= PORT0;
      slot_we_q    <= 1'b0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      slot_pc_q    <= '0;
      slot_oor_q   <= 1'b0;
      last_grant_q <= PORT1;
      ret_valid_q  <= 1'b0;
      ret_port_q   <= PORT0;
      ret_err_q    <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_port_q  <= slot_port_d;
      slot_we_q    <= slot_we_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      slot_pc_q    <= slot_pc_d;
      slot_oor_q   <= slot_oor_d;
      last_grant_q <= last_grant_d;
      ret_valid_q  <= ret_valid_d;
      ret_port_q   <= ret_port_d;
      ret_err_q    <= ret_err_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  assign bus.p0_gnt    = slot_valid_q & (slot_port_q == PORT0);
  assign bus.p1_gnt    = slot_valid_q & (slot_port_q == PORT1);
  assign bus.dm_addr   = slot_addr_q;
  assign bus.dm_wdata  = slot_wdata_q;
  assign bus.dm_pc     = slot_pc_q;
  // Gating by reset stops a write from committing when reset lands in the access cycle.
  assign bus.dm_wen    = slot_valid_q &  slot_we_q & ~slot_oor_q & ~reset;
  assign bus.dm_ren    = slot_valid_q & ~slot_we_q & ~slot_oor_q & ~reset;

  assign bus.p0_rvalid = ret_valid_q & (ret_port_q == PORT0);
  assign bus.p1_rvalid = ret_valid_q & (ret_port_q == PORT1);
  assign bus.p0_err    = bus.p0_rvalid & ret_err_q;
  assign bus.p1_err    = bus.p1_rvalid & ret_err_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: behavioural data memory, reference memory and
// a return scoreboard (expected read returns queued when requests are driven).
module tb_dm_arbiter;
  localparam int unsigned DEPTH  = 1024;
  localparam logic [31:0] DBG_PC = 32'hD000_0000;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } ret_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_arbiter_if bus();

  dm_arbiter #(.DEPTH_WORDS(DEPTH), .DBG_PC(DBG_PC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  ret_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  assign bus.dm_rdata = mem[bus.dm_addr[11:2]];
  always @(posedge clk) if (bus.dm_wen) mem[bus.dm_addr[11:2]] <= bus.dm_wdata;

  // Scoreboard: every rvalid pops the oldest expected return.
  always @(negedge clk) begin
    ret_t e, o;
    if (bus.p0_rvalid || bus.p1_rvalid) begin
      checks++;
      o.port  = bus.p1_rvalid;
      o.rdata = bus.p1_rvalid ? bus.p1_rdata : bus.p0_rdata;
      o.err   = bus.p1_rvalid ? bus.p1_err : bus.p0_err;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid got port=%0b rdata=%h err=%0b want no return", o.port, o.rdata, o.err);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL return got port=%0b rdata=%h err=%0b want port=%0b rdata=%h err=%0b",
                   o.port, o.rdata, o.err, e.port, e.rdata, e.err);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_pc = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
  endtask

  task automatic test_reset();
    logic [167:0] outs;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    outs = {bus.p0_gnt, bus.p0_rvalid, bus.p0_rdata, bus.p0_err,
            bus.p1_gnt, bus.p1_rvalid, bus.p1_rdata, bus.p1_err,
            bus.dm_addr, bus.dm_wdata, bus.dm_ren, bus.dm_wen, bus.dm_pc};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", outs);
    end
    reset = 1'b0;
  endtask

  task automatic test_read();
    logic [67:0] got;
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    @(negedge clk);
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h10; bus.p0_pc = 32'h100;
    exp_q.push_back({1'b0, ref_mem[4], 1'b0});
    @(negedge clk);
    got = {bus.p0_gnt, bus.p1_gnt, bus.dm_ren, bus.dm_wen, bus.dm_addr, bus.dm_pc};
    checks++;
    if (got !== {4'b1010, 32'h10, 32'h100}) begin
      errors++; $display("FAIL read_access got=%h want=%h", got, {4'b1010, 32'h10, 32'h100});
    end
    bus.p0_req = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rdata_hold got rvalid=%0b rdata=%h want rvalid=0 rdata=deadbeef",
                         bus.p0_rvalid, bus.p0_rdata);
    end
  endtask

  task automatic test_write_read_p1();
    logic [99:0] got;
    bit found = 0;
    @(negedge clk);
    bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 32'h20; bus.p1_wdata = 32'h12345678;
    ref_mem[8] = 32'h12345678;
    exp_q.push_back({1'b1, 32'h0, 1'b0});
    @(negedge clk);
    got = {bus.p0_gnt, bus.p1_gnt, bus.dm_ren, bus.dm_wen, bus.dm_addr, bus.dm_wdata, bus.dm_pc};
    checks++;
    if (got !== {4'b0101, 32'h20, 32'h12345678, DBG_PC}) begin
      errors++; $display("FAIL p1_write_access got=%h want=%h", got, {4'b0101, 32'h20, 32'h12345678, DBG_PC});
    end
    bus.p1_we = 0;
    exp_q.push_back({1'b1, ref_mem[8], 1'b0});
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (bus.p1_gnt) found = 1;
    end
    checks++;
    if (!found || bus.dm_ren !== 1'b1 || bus.dm_addr !== 32'h20) begin
      errors++; $display("FAIL p1_read_access got gnt=%0b ren=%0b addr=%h want gnt=1 ren=1 addr=20",
                         found, bus.dm_ren, bus.dm_addr);
    end
    bus.p1_req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_oor();
    bit found = 0;
    @(negedge clk);
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h1000;
    exp_q.push_back({1'b0, 32'h0, 1'b1});
    @(negedge clk);
    checks++;
    if ({bus.p0_gnt, bus.dm_ren, bus.dm_wen} !== 3'b100) begin
      errors++; $display("FAIL oor_access got gnt/ren/wen=%b want 100", {bus.p0_gnt, bus.dm_ren, bus.dm_wen});
    end
    bus.p0_addr = 32'hFFC;
    exp_q.push_back({1'b0, ref_mem[1023], 1'b0});
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (bus.p0_gnt) found = 1;
    end
    checks++;
    if (!found || bus.dm_ren !== 1'b1) begin
      errors++; $display("FAIL last_word_access got gnt=%0b ren=%0b want gnt=1 ren=1", found, bus.dm_ren);
    end
    bus.p0_req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h10; bus.p0_pc = 32'h200;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, ref_mem[4], 1'b0});
      exp_q.push_back({1'b1, ref_mem[8], 1'b0});
    end
    for (int i = 0; i < 6; i++) begin
      logic want0;
      @(negedge clk);
      want0 = (i % 2 == 0);
      checks++;
      if ({bus.p0_gnt, bus.p1_gnt} !== {want0, ~want0}) begin
        errors++; $display("FAIL b2b_gnt[%0d] got=%b want=%b", i, {bus.p0_gnt, bus.p1_gnt}, {want0, ~want0});
      end
    end
    bus.p0_req = 0; bus.p1_req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h10;
    repeat (3) exp_q.push_back({1'b0, ref_mem[4], 1'b0});
    for (int i = 0; i < 6; i++) begin
      logic want0;
      @(negedge clk);
      want0 = (i % 2 == 0);
      checks++;
      if ({bus.p0_gnt, bus.p1_gnt} !== {want0, 1'b0}) begin
        errors++; $display("FAIL single_gnt[%0d] got=%b want=%b", i, {bus.p0_gnt, bus.p1_gnt}, {want0, 1'b0});
      end
    end
    bus.p0_req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_tie();
    logic first1;
`ifdef DM_ARB_FIXED_PRIO_EN
    first1 = 1'b0;
`else
    first1 = 1'b1;
`endif
    @(negedge clk);
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h10;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h20;
    exp_q.push_back({first1,  first1 ? ref_mem[8] : ref_mem[4], 1'b0});
    exp_q.push_back({~first1, first1 ? ref_mem[4] : ref_mem[8], 1'b0});
    for (int i = 0; i < 2; i++) begin
      logic w1;
      @(negedge clk);
      w1 = (i == 0) ? first1 : ~first1;
      checks++;
      if ({bus.p0_gnt, bus.p1_gnt} !== {~w1, w1}) begin
        errors++; $display("FAIL tie_gnt[%0d] got=%b want=%b", i, {bus.p0_gnt, bus.p1_gnt}, {~w1, w1});
      end
    end
    bus.p0_req = 0; bus.p1_req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [167:0] outs;
    @(negedge clk);
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 32'h30; bus.p0_wdata = 32'h55;
    @(negedge clk);
    checks++;
    if ({bus.p0_gnt, bus.dm_wen} !== 2'b11) begin
      errors++; $display("FAIL midreset_grant got gnt/wen=%b want 11", {bus.p0_gnt, bus.dm_wen});
    end
    reset = 1'b1;
    bus.p0_req = 0; bus.p0_we = 0;
    #1;
    checks++;
    if (bus.dm_wen !== 1'b0) begin
      errors++; $display("FAIL midreset_wen got=%0b want=0", bus.dm_wen);
    end
    @(negedge clk);
    outs = {bus.p0_gnt, bus.p0_rvalid, bus.p0_rdata, bus.p0_err,
            bus.p1_gnt, bus.p1_rvalid, bus.p1_rdata, bus.p1_err,
            bus.dm_addr, bus.dm_wdata, bus.dm_ren, bus.dm_wen, bus.dm_pc};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL midreset_outputs got=%h want=0", outs);
    end
    reset = 1'b0;
    bus.p0_req = 1; bus.p0_addr = 32'h30;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h20;
    exp_q.push_back({1'b0, ref_mem[12], 1'b0});
    exp_q.push_back({1'b1, ref_mem[8], 1'b0});
    for (int i = 0; i < 2; i++) begin
      logic w1;
      @(negedge clk);
      w1 = (i == 1);
      checks++;
      if ({bus.p0_gnt, bus.p1_gnt} !== {~w1, w1}) begin
        errors++; $display("FAIL midreset_regrant[%0d] got=%b want=%b", i, {bus.p0_gnt, bus.p1_gnt}, {~w1, w1});
      end
    end
    bus.p0_req = 0; bus.p1_req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wr_rd_same();
    logic [98:0] got;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 32'h4; bus.p0_wdata = 32'hA; bus.p0_pc = 32'h300;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h4;
    ref_mem[1] = 32'hA;
    exp_q.push_back({1'b0, 32'h0, 1'b0});
    exp_q.push_back({1'b1, ref_mem[1], 1'b0});
    @(negedge clk);
    got = {bus.p0_gnt, bus.p1_gnt, bus.dm_wen, bus.dm_addr, bus.dm_wdata, bus.dm_pc};
    checks++;
    if (got !== {3'b101, 32'h4, 32'hA, 32'h300}) begin
      errors++; $display("FAIL wr_same_access got=%h want=%h", got, {3'b101, 32'h4, 32'hA, 32'h300});
    end
    bus.p0_req = 0; bus.p0_we = 0;
    @(negedge clk);
    checks++;
    if ({bus.p1_gnt, bus.dm_ren, bus.dm_addr} !== {2'b11, 32'h4}) begin
      errors++; $display("FAIL rd_same_access got=%h want=%h", {bus.p1_gnt, bus.dm_ren, bus.dm_addr}, {2'b11, 32'h4});
    end
    bus.p1_req = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'hA5A5_0000 | i;
      ref_mem[i] = 32'hA5A5_0000 | i;
    end
    test_reset();
    test_read();
    test_write_read_p1();
    test_oor();
    test_back_to_back();
    test_single();
    test_tie();
    test_reset_mid();
    test_wr_rd_same();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL missing_returns got=%0d pending want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single data memory (1024 words, combinational read, write on posedge clk) between two requesters.
- Port 0 is the CPU MEM stage. Port 1 is the debug/loader port.
- Registered single-cycle access scheduler: one dm access per cycle, round-robin between ports, registered read return with error flag for out-of-range addresses.
- Sits between the requesters and the dm address/data/enable/pc inputs.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in dm; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- DBG_PC, 32'h0000_0000, value driven on dm_pc for port-1 accesses.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- p0_req  in  1  port 0 access request; held with we/addr/wdata/pc until p0_gnt
- p0_we  in  1  1 = write, 0 = read
- p0_addr  in  32  byte address; bits [1:0] ignored
- p0_wdata  in  32  write data
- p0_pc  in  32  pc of the requesting instruction, forwarded to dm_pc
- p0_gnt  out  1  access-cycle pulse for port 0
- p0_rvalid  out  1  read data / error valid, one cycle after p0_gnt
- p0_rdata  out  32  read data
- p0_err  out  1  out-of-range address on the returned access
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0, with no pc input
- dm_addr  out  32  to dm ReadAddr and WriteAddr
- dm_wdata  out  32  to dm WriteData
- dm_ren  out  1  to dm ReadEn
- dm_wen  out  1  to dm WriteEn
- dm_pc  out  32  to dm pc

Behaviour:
- State is a registered access slot (valid, port, we, addr, wdata, pc, oor) plus a 1-bit last_grant pointer.
- Reset values:
  - slot invalid; last_grant = 1, so port 0 wins the first tie.
  - All outputs 0: dm_ren, dm_wen, gnt, rvalid, err, rdata, dm_addr, dm_wdata, dm_pc.
- Cycle N (select):
  - Eligible ports are those with req=1, excluding the port currently occupying the slot.
  - That port's req is still high during its own gnt cycle, so it is masked and never double-granted.
  - Winner: if one port is eligible, it wins. If both are eligible, the port != last_grant wins.
  - Winner's fields are loaded into the slot at the posedge ending N; last_grant updates to the winner.
  - No eligible port: slot becomes invalid.
- Cycle N+1 (access):
  - pX_gnt = 1 for the slot port. Requester may drop or change its request from cycle N+2.
  - dm_addr = slot addr and dm_wdata = slot wdata.
  - dm_pc = p0 pc or DBG_PC.
  - dm_wen = valid & we & ~oor; dm_ren = valid & ~we & ~oor.
  - Writes commit at the posedge ending N+1.
- Cycle N+2 (return):
  - pX_rvalid = 1 for one cycle, for both reads and writes.
  - pX_rdata = dm ReadData captured at the end of N+1 for reads, and 0 for writes or oor.
  - pX_err = oor.
  - rdata holds its value when rvalid=0.
- Range check: oor = addr[31:2] >= DEPTH_WORDS, computed at slot load. An oor slot performs no dm access but still gnt/rvalid as normal.
- Throughput:
  - Two continuously requesting ports alternate every cycle, 1 access/cycle total.
  - A single requester gets at most 1 access every 2 cycles, because of the masking.
- Write-then-read to the same word on consecutive slots returns the new data, since the dm write happens before the next access cycle.
- Reset mid-operation: slot is cleared, no dm_wen in the following cycle, pending rvalid is suppressed, last_grant returns to 1.
- Requests never drop before gnt. Dropping req before gnt is illegal; the arbiter behaviour is then undefined for that request.

Optional Feature:
- Macro DM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both ports are eligible. last_grant still updates but is ignored. Port 1 is served only in cycles where port 0 is masked or idle.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset then p0 read of 0x10 with MEM[4]=0xDEADBEEF -> p0_gnt in cycle 2 with dm_ren=1 and dm_addr=0x10; p0_rvalid in cycle 3 with rdata=0xDEADBEEF and err=0.
- p1 write of addr 0x20, data 0x12345678, then p1 read of 0x20 -> dm_wen=1 with dm_pc=DBG_PC in the first gnt cycle; the read returns 0x12345678.
- p0 and p1 both holding req asserted from reset for 6 cycles -> gnt order p0,p1,p0,p1,p0,p1 with no idle slot. Under DM_ARB_FIXED_PRIO_EN the order is p0,p1,p0,p1 only because of masking; with p0 re-requesting immediately, p1 never wins two in a row.
- p0 read of 0x1000 (word 1024) -> gnt, then dm_ren=0 and dm_wen=0, then p0_rvalid=1 with err=1 and rdata=0.
- p0 write granted (slot loaded) and reset asserted in the access cycle -> no write to dm, no rvalid, all outputs 0 in the next cycle.
- p0 write of 0x4 with data 0xA in slot k and p1 read of 0x4 in slot k+1 -> p1_rdata=0xA.
